// File: rtl/contador_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : contador_ctrl
//  Description : Run/pause/stop controlled up-counter with a one-shot or
//                periodic terminal count, a reload tick pulse and a
//                saturating count of completed periods.
//  Revision    : 1.0 - initial release
// ============================================================================
module contador_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             periodic,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tick,
  output logic [WIDTH-1:0] wraps
);

  localparam logic [WIDTH-1:0] c_zero = '0;
  localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);
  localparam logic [WIDTH-1:0] c_max  = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_wraps;
  logic [WIDTH-1:0] r_limit_q;
  logic             r_periodic_q;
  logic             r_busy;
  logic             r_done;
  logic             r_tick;

  // Terminal condition is evaluated against the value latched at start, so
  // later changes on the limit input cannot disturb a run in progress.
  logic w_at_limit;
  assign w_at_limit = (r_count == r_limit_q);

  // Control FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_count      <= c_zero;
      r_wraps      <= c_zero;
      r_limit_q    <= c_zero;
      r_periodic_q <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_tick       <= 1'b0;
    end else begin
      // tick is a single-cycle pulse: only the reload branch re-asserts it
      r_tick <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_limit_q    <= limit;
            r_periodic_q <= periodic;
            r_count      <= c_zero;
            r_wraps      <= c_zero;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_state      <= ST_RUN;
          end
        end

        ST_RUN: begin
          // priority: stop, then pause, then terminal count, then increment
          if (stop) begin
            r_count <= c_zero;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (pause) begin
            r_state <= ST_PAUSE;
          end else if (w_at_limit) begin
            if (r_periodic_q) begin
              r_count <= c_zero;
              r_tick  <= 1'b1;
              if (r_wraps != c_max) begin
                r_wraps <= r_wraps + c_one;
              end
            end else begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end else begin
            r_count <= r_count + c_one;
          end
        end

        ST_PAUSE: begin
          // leaving pause only re-arms RUN; the count moves on the next edge
          if (stop) begin
            r_count <= c_zero;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (!pause) begin
            r_state <= ST_RUN;
          end
        end

        ST_DONE: begin
          if (stop) begin
            r_count <= c_zero;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_state <= ST_IDLE;
          end else if (start) begin
            r_limit_q    <= limit;
            r_periodic_q <= periodic;
            r_count      <= c_zero;
            r_wraps      <= c_zero;
            r_busy       <= 1'b1;
            r_done       <= 1'b0;
            r_state      <= ST_RUN;
          end
        end

        default: begin
          r_count <= c_zero;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign count = r_count;
  assign busy  = r_busy;
  assign done  = r_done;
  assign tick  = r_tick;
  assign wraps = r_wraps;

endmodule
`default_nettype wire

// File: tb/tb_contador_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_contador_ctrl
//  Description : Self-checking bench for contador_ctrl. A driver applies
//                directed and random stimulus and queues the response a
//                behavioural model predicts; a monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_contador_ctrl;

  localparam int WIDTH = 4;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             stop;
  logic             pause;
  logic             periodic;
  logic [WIDTH-1:0] limit;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             tick;
  logic [WIDTH-1:0] wraps;

  always #5 clk = ~clk;

  contador_ctrl #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .periodic (periodic),
    .limit    (limit),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .tick     (tick),
    .wraps    (wraps)
  );

  typedef struct packed {
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;
    logic             tick;
    logic [WIDTH-1:0] wraps;
  } resp_t;

  resp_t exp_q[$];
  resp_t mon_exp;
  resp_t mon_act;
  int    checks = 0;
  int    errors = 0;
  int    cycle  = 0;

  // ---------------- behavioural reference model ----------------
  typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mode_t;
  mode_t m_mode = M_IDLE;
  int    m_cnt  = 0;
  int    m_wr   = 0;
  int    m_lim  = 0;
  bit    m_per  = 0;
  bit    m_tick = 0;

  task automatic model_edge(input bit r, input bit st, input bit sp, input bit pa,
                            input bit per, input int lim);
    m_tick = 0;
    if (!r) begin
      m_mode = M_IDLE; m_cnt = 0; m_wr = 0; m_lim = 0; m_per = 0;
    end else if ((m_mode == M_IDLE || m_mode == M_DONE) && st && !(m_mode == M_DONE && sp)) begin
      m_mode = M_RUN; m_lim = lim; m_per = per; m_cnt = 0; m_wr = 0;
    end else if (m_mode != M_IDLE && sp) begin
      m_mode = M_IDLE; m_cnt = 0;
    end else if (m_mode == M_PAUSE) begin
      if (!pa) m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      if (pa) m_mode = M_PAUSE;
      else if (m_cnt == m_lim) begin
        if (m_per) begin
          m_cnt = 0; m_tick = 1;
          if (m_wr < MAXV) m_wr = m_wr + 1;
        end else begin
          m_mode = M_DONE;
        end
      end else m_cnt = m_cnt + 1;
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, queue the prediction.
  task automatic step(input bit r, input bit st, input bit sp, input bit pa,
                      input bit per, input int lim);
    resp_t e;
    reset = r; start = st; stop = sp; pause = pa; periodic = per;
    limit = WIDTH'(lim);
    @(posedge clk);
    model_edge(r, st, sp, pa, per, lim);
    e.count = WIDTH'(m_cnt);
    e.busy  = (m_mode == M_RUN) || (m_mode == M_PAUSE);
    e.done  = (m_mode == M_DONE);
    e.tick  = m_tick;
    e.wraps = WIDTH'(m_wr);
    exp_q.push_back(e);
    #1;
  endtask

  // idle cycle with garbage on limit/periodic, which must not matter
  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1, 0, 0, 0, 1'($urandom), int'($urandom_range(0, MAXV)));
  endtask

  task automatic go(input bit per, input int lim);
    step(1, 1, 0, 0, per, lim);
  endtask

  task automatic halt();
    step(1, 0, 1, 0, 0, 0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      cycle++;
      if (exp_q.size() > 0) begin
        mon_exp = exp_q.pop_front();
        mon_act = {count, busy, done, tick, wraps};
        checks++;
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL outputs@cycle%0d: got count=%0d busy=%b done=%b tick=%b wraps=%0d, expected count=%0d busy=%b done=%b tick=%b wraps=%0d",
                   cycle, mon_act.count, mon_act.busy, mon_act.done, mon_act.tick, mon_act.wraps,
                   mon_exp.count, mon_exp.busy, mon_exp.done, mon_exp.tick, mon_exp.wraps);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
    periodic = 1'b0; limit = '0;
    #2;
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 9);   // reset overrides start
    idle(2);

    // one-shot to 5, then start again straight from DONE
    go(0, 5);
    idle(9);
    go(1, 2);
    idle(4);
    halt();
    idle(1);

    // periodic limit 3, then stop keeps wraps
    go(1, 3);
    idle(11);
    halt();
    idle(2);

    // pause at count 2 for three cycles
    go(0, 6);
    idle(2);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 0, 0);
    idle(8);
    halt();

    // start with another limit is ignored mid-run; then stop+pause+start at 4
    go(0, 9);
    step(1, 1, 0, 0, 1, 2);
    idle(2);
    step(1, 1, 0, 0, 0, 1);
    step(1, 1, 1, 1, 0, 2);
    idle(2);

    // limit 0 periodic: tick every cycle, wraps saturates
    go(1, 0);
    idle(20);
    halt();
    idle(1);

    // limit 0 one-shot
    go(0, 0);
    idle(3);
    halt();

    // reset mid-run at count 3, then a normal run
    go(1, 7);
    idle(3);
    step(0, 0, 0, 0, 1, 5);
    idle(1);
    go(0, 4);
    idle(7);
    halt();

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 59) != 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 14) == 0),
           ($urandom_range(0, 4) == 0),
           1'($urandom),
           ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, MAXV)));
    end
    idle(3);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending responses, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
